// File: rtl/uart_tx_frame.sv
// UART transmit framer: configurable width, oversample, parity, stop bits,
// valid/ready input and line-break generation.
module uart_tx_frame #(
  parameter int DATA_W     = 8,
  parameter int OS_RATE    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk_tf,
  input  logic              rst_tf,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              tx_break,
  output logic              transmitter_tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int OSW = $clog2(OS_RATE);
  localparam int BCW = $clog2(DATA_W + 1);

  localparam logic [OSW-1:0] OS_LAST  = OSW'(OS_RATE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);
  localparam logic           STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic [2:0]        state;
  logic [OSW-1:0]    os_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic              stop_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              framed;
  logic              line;
  logic              bit_end;

  assign bit_end        = (os_cnt == OS_LAST);
  assign tx_ready       = (state == S_IDLE) && !rst_tf;
  assign tx_busy        = (state != S_IDLE);
  assign transmitter_tx = line;

  always_ff @(posedge clk_tf) begin
    if (rst_tf) begin
      state    <= S_IDLE;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      framed   <= 1'b0;
      line     <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      // IDLE and BREAK hold the oversample counter at zero
      if (state != S_IDLE && state != S_BREAK) begin
        os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (tx_break) begin
            state <= S_BREAK;
            line  <= 1'b0;
          end else if (tx_valid && tx_ready) begin
            state   <= S_START;
            line    <= 1'b0;
            shreg   <= tx_data;
            par_bit <= (^tx_data) ^ (PARITY_ODD != 0);
            framed  <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            line    <= shreg[0];
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state <= S_PARITY;
                line  <= par_bit;
              end else begin
                state    <= S_STOP;
                line     <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              shreg   <= shreg >> 1;
              line    <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            line     <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              state   <= S_IDLE;
              tx_done <= framed;
              framed  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (!tx_break) begin
            state    <= S_STOP;
            line     <= 1'b1;
            stop_cnt <= 1'b0;
            framed   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          line  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: per-cycle expected line/busy/done/ready
// are queued when a frame is launched and popped every cycle.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_break = 1'b0;
  logic [4:0] line, rdy, busy, done;
  logic [2:0] sel = '0;
  logic [3:0] obs;

  logic [3:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_tx_frame u0 (
    .clk_tf(clk), .rst_tf(rst), .tx_data(tx_data[7:0]),
    .tx_valid(tx_valid), .tx_ready(rdy[0]), .tx_break(tx_break),
    .transmitter_tx(line[0]), .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_frame #(.PARITY_EN(1)) u1 (
    .clk_tf(clk), .rst_tf(rst), .tx_data(tx_data[7:0]),
    .tx_valid(tx_valid), .tx_ready(rdy[1]), .tx_break(tx_break),
    .transmitter_tx(line[1]), .tx_busy(busy[1]), .tx_done(done[1]));

  uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk_tf(clk), .rst_tf(rst), .tx_data(tx_data[7:0]),
    .tx_valid(tx_valid), .tx_ready(rdy[2]), .tx_break(tx_break),
    .transmitter_tx(line[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  uart_tx_frame #(.STOP_BITS(2)) u3 (
    .clk_tf(clk), .rst_tf(rst), .tx_data(tx_data[7:0]),
    .tx_valid(tx_valid), .tx_ready(rdy[3]), .tx_break(tx_break),
    .transmitter_tx(line[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  uart_tx_frame #(.DATA_W(5), .OS_RATE(3)) u4 (
    .clk_tf(clk), .rst_tf(rst), .tx_data(tx_data[4:0]),
    .tx_valid(tx_valid), .tx_ready(rdy[4]), .tx_break(tx_break),
    .transmitter_tx(line[4]), .tx_busy(busy[4]), .tx_done(done[4]));

  always_comb begin
    obs = {line[sel], busy[sel], done[sel], rdy[sel]};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (line,busy,done,ready)",
               tag, got, exp);
    else
      passed++;
  endtask

  function automatic logic [3:0] ent(input logic l, input logic b,
                                     input logic d, input logic r);
    return {l, b, d, r};
  endfunction

  task automatic push_n(input logic [3:0] e, input int n);
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [8:0] d, input int dw, input int os,
                            input int pen, input int podd, input int sb);
    logic p;
    p = (podd != 0);
    push_n(ent(1'b0, 1'b1, 1'b0, 1'b0), os);
    for (int i = 0; i < dw; i++) begin
      push_n(ent(d[i], 1'b1, 1'b0, 1'b0), os);
      p = p ^ d[i];
    end
    if (pen != 0) push_n(ent(p, 1'b1, 1'b0, 1'b0), os);
    push_n(ent(1'b1, 1'b1, 1'b0, 1'b0), sb * os);
    push_n(ent(1'b1, 1'b0, 1'b1, 1'b1), 1);
  endtask

  task automatic run_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      chk($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(exp_q.pop_front()));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_break = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk({tag, "_rst"}, 32'(obs), 32'(ent(1'b1, 1'b0, 1'b0, 1'b0)));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_rdy"}, 32'(obs), 32'(ent(1'b1, 1'b0, 1'b0, 1'b1)));
  endtask

  task automatic start_frame(input logic [8:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single 8N1 frame
    sel = 3'd0;
    do_reset("a5");
    push_frame(9'h0A5, 8, 16, 0, 0, 1);
    start_frame(9'h0A5);
    tx_valid = 1'b0;
    run_n("a5", exp_q.size());

    // even parity 0x07 then 0x03, odd parity 0x07
    sel = 3'd1;
    do_reset("pe");
    push_frame(9'h007, 8, 16, 1, 0, 1);
    start_frame(9'h007);
    tx_valid = 1'b0;
    run_n("pe07", exp_q.size());
    push_frame(9'h003, 8, 16, 1, 0, 1);
    start_frame(9'h003);
    tx_valid = 1'b0;
    run_n("pe03", exp_q.size());
    sel = 3'd2;
    do_reset("po");
    push_frame(9'h007, 8, 16, 1, 1, 1);
    start_frame(9'h007);
    tx_valid = 1'b0;
    run_n("po07", exp_q.size());

    // back-to-back 8N2, data changed after capture
    sel = 3'd3;
    do_reset("b2b");
    push_frame(9'h055, 8, 16, 0, 0, 2);
    push_frame(9'h0AA, 8, 16, 0, 0, 2);
    start_frame(9'h055);
    tx_data = 9'h0AA;
    run_n("b2b1", 177);
    tx_valid = 1'b0;
    run_n("b2b2", exp_q.size());

    // break with a pending frame
    sel = 3'd0;
    do_reset("brk");
    push_n(ent(1'b0, 1'b1, 1'b0, 1'b0), 100);
    push_n(ent(1'b1, 1'b1, 1'b0, 1'b0), 16);
    push_n(ent(1'b1, 1'b0, 1'b0, 1'b1), 1);
    push_frame(9'h03C, 8, 16, 0, 0, 1);
    @(negedge clk);
    tx_data  = 9'h03C;
    tx_valid = 1'b1;
    tx_break = 1'b1;
    @(posedge clk);
    #1;
    run_n("brk", 99);
    tx_break = 1'b0;
    run_n("brkstop", 18);
    tx_valid = 1'b0;
    run_n("brkfrm", exp_q.size());

    // reset during data bit 3, then clean frame
    do_reset("mid");
    push_frame(9'h096, 8, 16, 0, 0, 1);
    start_frame(9'h096);
    tx_valid = 1'b0;
    run_n("mid", 55);
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_line", 32'(obs), 32'(ent(1'b1, 1'b0, 1'b0, 1'b0)));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rdy", 32'(obs), 32'(ent(1'b1, 1'b0, 1'b0, 1'b1)));
    push_n(ent(1'b1, 1'b0, 1'b0, 1'b1), 20);
    run_n("mid_idle", 20);
    push_frame(9'h03C, 8, 16, 0, 0, 1);
    start_frame(9'h03C);
    tx_valid = 1'b0;
    run_n("mid3c", exp_q.size());

    // odd geometry 5N1 at 3x, upper data bits driven high
    sel = 3'd4;
    do_reset("odd");
    push_frame(9'h1FF, 5, 3, 0, 0, 1);
    start_frame(9'h1FF);
    tx_valid = 1'b0;
    run_n("odd", exp_q.size());
    push_frame(9'h0EA, 5, 3, 0, 0, 1);
    start_frame(9'h0EA);
    tx_valid = 1'b0;
    run_n("odd2", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit framer: next generation of the fixed 8N1 transmitter, with configurable data width, oversample rate, parity and stop-bit count, plus a valid/ready input handshake and line-break generation. Sits in the `clk_tf` domain, fed directly by a FIFO read port or a bus-side skid buffer, and drives the serial line pin. One bit period is `OS_RATE` cycles of `clk_tf`.

## Interface

- `DATA_W`, default 8: data bits per frame; legal range 5..9.
- `OS_RATE`, default 16: `clk_tf` cycles per bit; must be ≥ 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 means even parity, 1 means odd; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:

- `clk_tf` in 1: the block's only clock; all logic runs on its rising edge.
- `rst_tf` in 1: synchronous, active-high reset.
- `tx_data` in `DATA_W`: frame payload, captured on acceptance.
- `tx_valid` in 1: payload valid.
- `tx_ready` out 1: block can accept a frame.
- `tx_break` in 1: request to hold the line low (break condition).
- `transmitter_tx` out 1: serial line output, idle high, registered.
- `tx_busy` out 1: high whenever the state is not IDLE.
- `tx_done` out 1: one-cycle pulse at the end of each data frame.

## Operation

- **States:** IDLE, START, DATA, PARITY, STOP, BREAK.
- **Reset values** (apply while `rst_tf` is high): state IDLE, `transmitter_tx` = 1, `tx_ready` = 0, `tx_busy` = 0, `tx_done` = 0, all counters 0.
  - `tx_ready` = 1 from the first cycle after `rst_tf` falls.
- **`tx_ready`** is high only in IDLE and only outside reset.
- **IDLE:**
  - If `tx_break` = 1, go to BREAK. Break has priority over `tx_valid`, and no frame is accepted that cycle.
  - Else if `tx_valid` && `tx_ready`, capture `tx_data` into the shift register and go to START.
  - `tx_data` changes after capture have no effect.
- **START:** line driven 0 for `OS_RATE` cycles, then go to DATA.
- **DATA:**
  - Bits sent LSB first, each for `OS_RATE` cycles.
  - After `DATA_W` bits, go to PARITY if `PARITY_EN` = 1, else to STOP.
- **PARITY:**
  - Line = XOR of the captured data (even), or its complement (odd).
  - Held for `OS_RATE` cycles, then go to STOP.
- **STOP:** line 1 for `STOP_BITS` × `OS_RATE` cycles, then go to IDLE.
  - `tx_done` pulses only when STOP was entered from DATA or PARITY.
- **BREAK:**
  - Line 0 and `tx_ready` = 0 for as long as `tx_break` = 1.
  - On the first cycle `tx_break` is sampled 0, go to STOP. This guarantees the full stop time.
  - No `tx_done` at the end of the following STOP.
- **Counters:**
  - Oversample counter is `$clog2(OS_RATE)` bits wide; it counts 0..`OS_RATE`−1 and wraps to 0 on every bit boundary, including when `OS_RATE` is not a power of two.
  - Bit counter is `$clog2(DATA_W+1)` bits wide.
  - A stop-bit counter handles `STOP_BITS` = 2.
- **Reset mid-frame:**
  - Frame is abandoned; no `tx_done`.
  - Line returns to 1 on the cycle `rst_tf` is sampled.
  - The next accepted frame is transmitted cleanly from its start bit.

## Timing

- Acceptance edge is E. `transmitter_tx` goes 0 on the cycle after E. Latency from handshake to start bit: 1 cycle.
- Frame length F = (1 + `DATA_W` + `PARITY_EN` + `STOP_BITS`) × `OS_RATE` cycles. Line cycles E+1 .. E+F carry the frame.
- Cycle E+F+1 is IDLE:
  - `tx_done` = 1 and `tx_ready` = 1 in that cycle, `tx_busy` = 0.
  - A frame accepted at that edge starts at E+F+2.
  - Back-to-back frame period is therefore F+1 cycles (one extra idle-high cycle).
- `tx_busy` is high exactly from E+1 through E+F.
- Bit transitions occur only at multiples of `OS_RATE` cycles after the start-bit edge; there are no glitches within a bit.

## Test plan

- **Single 8N1 frame:** `OS_RATE`=16, send 0xA5.
  - Line 0 for cycles 1–16, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for cycles 145–160.
  - `tx_done` at cycle 161; `tx_busy` high for exactly 160 cycles.
- **Parity:** `PARITY_EN`=1.
  - Data 0x07: even gives parity bit 1; odd gives 0.
  - Data 0x03: even gives 0.
  - Frame length 176 cycles in each case.
- **Back-to-back 8N2:** `STOP_BITS`=2, `tx_valid` held high with 0x55 then 0xAA.
  - Second start bit begins exactly 177 cycles after the first.
  - `tx_ready` is high for only one cycle between frames.
- **Break:** `tx_break` held for 100 cycles while `tx_valid`=1.
  - Line 0 for 100 cycles, then 1 for `STOP_BITS`×`OS_RATE` cycles.
  - No frame is accepted during break; no `tx_done` for the break.
  - The pending frame is then accepted.
- **Reset during data bit 3:**
  - Line 1 from the reset cycle; `tx_done` never asserts.
  - `tx_ready` = 1 one cycle after reset release.
  - A following 0x3C frame is bit-exact.
- **Odd geometry:** `DATA_W`=5, `OS_RATE`=3, send 0x1F.
  - Bits are exactly 3 cycles wide; frame length 21 cycles.
  - Upper `tx_data` bits are ignored.
